// File: rtl/dma_bus_arbiter.sv
// CPU-side responder for a cycle-stealing DMA engine: kicks off a transfer on a
// device interrupt, grants the bus per burst once the CPU drains, and reports completion.
module dma_bus_arbiter #(
    parameter int BURSTS    = 3,
    parameter int MAX_GRANT = 8,
    parameter int GAP_MIN   = 1
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic dev_irq,
    input  logic cpu_mem_busy,
    input  logic BR,
    output logic cmd,
    output logic BG,
    output logic cpu_stall,
    output logic dma_done,
    output logic bus_error,
    output logic busy
);

    localparam int BW = $clog2(BURSTS + 1);
    localparam int GW = $clog2(MAX_GRANT + 1);
    localparam int PW = $clog2(GAP_MIN + 2);

    localparam logic [BW-1:0] BURST_LAST = BW'(BURSTS - 1);
    localparam logic [GW-1:0] GRANT_LAST = GW'(MAX_GRANT);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_MIN);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_REQ,
        DRAIN,
        GRANT,
        GAP,
        DONE
    } state_t;

    state_t        state;
    logic          dev_irq_q;
    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] grant_cnt;
    logic [PW-1:0] gap_cnt;

    // Outputs are loaded alongside the state transition, so each one reflects the state being entered.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            dev_irq_q <= 1'b0;
            burst_cnt <= '0;
            grant_cnt <= '0;
            gap_cnt   <= '0;
            cmd       <= 1'b0;
            BG        <= 1'b0;
            cpu_stall <= 1'b0;
            dma_done  <= 1'b0;
            bus_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dev_irq_q <= dev_irq;
            cmd       <= 1'b0;
            dma_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (dev_irq && !dev_irq_q) begin
                        state <= ISSUE;
                        cmd   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT_REQ;
                end
                WAIT_REQ: begin
                    if (BR) begin
                        cpu_stall <= 1'b1;
                        if (cpu_mem_busy) begin
                            state <= DRAIN;
                        end else begin
                            state     <= GRANT;
                            BG        <= 1'b1;
                            grant_cnt <= GW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!cpu_mem_busy) begin
                        state     <= GRANT;
                        BG        <= 1'b1;
                        grant_cnt <= GW'(1);
                    end
                end
                GRANT: begin
                    if (!BR) begin
                        BG        <= 1'b0;
                        cpu_stall <= 1'b0;
                        grant_cnt <= '0;
                        burst_cnt <= burst_cnt + 1'b1;
                        if (burst_cnt == BURST_LAST) begin
                            state    <= DONE;
                            dma_done <= 1'b1;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= PW'(1);
                        end
                    end else if (grant_cnt == GRANT_LAST) begin
                        // The engine overstayed its grant: abort the whole transfer without a completion.
                        state     <= IDLE;
                        BG        <= 1'b0;
                        cpu_stall <= 1'b0;
                        bus_error <= 1'b1;
                        busy      <= 1'b0;
                        burst_cnt <= '0;
                        grant_cnt <= '0;
                    end else begin
                        grant_cnt <= grant_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        state   <= WAIT_REQ;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    BG        <= 1'b0;
                    cpu_stall <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a vector table for a full three-burst transfer
// plus hand-written sequences for drain, async reset, spurious requests and grant timeout.
module tb_dma_bus_arbiter;

    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    logic dev_irq = 1'b0;
    logic cpu_mem_busy = 1'b0;
    logic BR = 1'b0;
    logic cmd, BG, cpu_stall, dma_done, bus_error, busy;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic irq;
        logic mbusy;
        logic br;
        logic cmd;
        logic bg;
        logic stall;
        logic done;
        logic err;
        logic busy;
    } vec_t;

    vec_t vecs [22];

    dma_bus_arbiter #(.BURSTS(3), .MAX_GRANT(8), .GAP_MIN(1)) dut (
        .CLK(CLK),
        .reset_n(reset_n),
        .dev_irq(dev_irq),
        .cpu_mem_busy(cpu_mem_busy),
        .BR(BR),
        .cmd(cmd),
        .BG(BG),
        .cpu_stall(cpu_stall),
        .dma_done(dma_done),
        .bus_error(bus_error),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drives inputs, then samples one time unit after the next rising edge.
    task automatic applyStimulus(input logic irq, input logic mbusy, input logic br);
        dev_irq = irq;
        cpu_mem_busy = mbusy;
        BR = br;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic ecmd, input logic ebg, input logic estall,
                            input logic edone, input logic eerr, input logic ebusy);
        checkOutput({tag, ".cmd"}, 8'(cmd), 8'(ecmd));
        checkOutput({tag, ".BG"}, 8'(BG), 8'(ebg));
        checkOutput({tag, ".cpu_stall"}, 8'(cpu_stall), 8'(estall));
        checkOutput({tag, ".dma_done"}, 8'(dma_done), 8'(edone));
        checkOutput({tag, ".bus_error"}, 8'(bus_error), 8'(eerr));
        checkOutput({tag, ".busy"}, 8'(busy), 8'(ebusy));
    endtask

    initial begin
        // {irq, mbusy, br} then {cmd, BG, cpu_stall, dma_done, bus_error, busy}
        vecs[0]  = 9'b100_100001;
        vecs[1]  = 9'b100_000001;
        vecs[2]  = 9'b000_000001;
        vecs[3]  = 9'b001_011001;
        vecs[4]  = 9'b001_011001;
        vecs[5]  = 9'b001_011001;
        vecs[6]  = 9'b001_011001;
        vecs[7]  = 9'b000_000001;
        vecs[8]  = 9'b001_000001;
        vecs[9]  = 9'b001_011001;
        vecs[10] = 9'b101_011001;
        vecs[11] = 9'b001_011001;
        vecs[12] = 9'b101_011001;
        vecs[13] = 9'b000_000001;
        vecs[14] = 9'b000_000001;
        vecs[15] = 9'b001_011001;
        vecs[16] = 9'b001_011001;
        vecs[17] = 9'b001_011001;
        vecs[18] = 9'b001_011001;
        vecs[19] = 9'b000_000101;
        vecs[20] = 9'b000_000000;
        vecs[21] = 9'b000_000000;

        repeat (2) @(posedge CLK);
        #1;
        checkAll("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].irq, vecs[i].mbusy, vecs[i].br);
            checkAll($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].bg, vecs[i].stall,
                     vecs[i].done, vecs[i].err, vecs[i].busy);
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("drain.cmd", 8'(cmd), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("drain%0d.BG", k), 8'(BG), 8'd0);
            checkOutput($sformatf("drain%0d.cpu_stall", k), 8'(cpu_stall), 8'd1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAll("drain_grant", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkAll("drain_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("burst2_grant.BG", 8'(BG), 8'd1);

        // Pull reset mid-cycle while the second burst holds the bus.
        #2;
        reset_n = 1'b0;
        #1;
        checkAll("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        BR = 1'b0;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_release.burst_cnt", 8'(dut.burst_cnt), 8'd0);
        checkOutput("reset_release.busy", 8'(busy), 8'd0);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkAll($sformatf("spurious%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("timeout.cmd", 8'(cmd), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkAll($sformatf("timeout%0d", k), 1'b0, (k <= 8), (k <= 8), 1'b0, (k >= 9), (k <= 8));
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'(k % 2));
            checkAll($sformatf("sticky%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
